// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared types for the dual-lane ID/EX stage: lane record, bubble constant,
// hazard-control state encoding and a lane issue helper.
package pipe_pkg;

  localparam int unsigned REG_W = 3;

  typedef logic [REG_W-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t rm;
    reg_t rn;
    reg_t rd;
    logic regwrite;
    logic memread;
    logic alusrcb;
  } lane_t;

  // All-zero slot: r0 addresses keep the forwarding unit from matching it.
  localparam lane_t BUBBLE = '0;

  typedef enum logic {
    RUN,
    SPLIT
  } hz_state_t;

  // An invalid decode slot always enters EX as a clean bubble.
  function automatic lane_t issue_lane(input lane_t l);
    return l.valid ? l : BUBBLE;
  endfunction

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// Decode-side inputs, EX-side control and the registered ID/EX lane fields
// of id_ex_hazard_stage.
interface id_ex_hazard_stage_if #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rm_1, id_rn_1, id_rd_1;
  logic [REG_W-1:0] id_rm_2, id_rn_2, id_rd_2;
  logic             id_regwrite_1, id_memread_1, id_alusrcb_1;
  logic             id_regwrite_2, id_memread_2, id_alusrcb_2;
  logic             ex_hold;
  logic             ex_branch_taken;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             ID_EX_valid_1, ID_EX_valid_2;
  logic [REG_W-1:0] ID_EX_rm_1, ID_EX_rn_1, ID_EX_rd_1;
  logic [REG_W-1:0] ID_EX_rm_2, ID_EX_rn_2, ID_EX_rd_2;
  logic             ID_EX_RegWrite_1, ID_EX_MemRead_1, ID_EX_ALUSrcB_1;
  logic             ID_EX_RegWrite_2, ID_EX_MemRead_2, ID_EX_ALUSrcB_2;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rm_1, id_rn_1, id_rd_1, id_rm_2, id_rn_2, id_rd_2,
           id_regwrite_1, id_memread_1, id_alusrcb_1,
           id_regwrite_2, id_memread_2, id_alusrcb_2,
           ex_hold, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush,
           ID_EX_valid_1, ID_EX_valid_2,
           ID_EX_rm_1, ID_EX_rn_1, ID_EX_rd_1, ID_EX_rm_2, ID_EX_rn_2, ID_EX_rd_2,
           ID_EX_RegWrite_1, ID_EX_MemRead_1, ID_EX_ALUSrcB_1,
           ID_EX_RegWrite_2, ID_EX_MemRead_2, ID_EX_ALUSrcB_2,
           stall_cnt
  );

  modport slave (
    input  id_valid, id_rm_1, id_rn_1, id_rd_1, id_rm_2, id_rn_2, id_rd_2,
           id_regwrite_1, id_memread_1, id_alusrcb_1,
           id_regwrite_2, id_memread_2, id_alusrcb_2,
           ex_hold, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush,
           ID_EX_valid_1, ID_EX_valid_2,
           ID_EX_rm_1, ID_EX_rn_1, ID_EX_rd_1, ID_EX_rm_2, ID_EX_rn_2, ID_EX_rd_2,
           ID_EX_RegWrite_1, ID_EX_MemRead_1, ID_EX_ALUSrcB_1,
           ID_EX_RegWrite_2, ID_EX_MemRead_2, ID_EX_ALUSrcB_2,
           stall_cnt
  );

endinterface

// File: rtl/id_ex_hazard_stage_hz_match.sv
// Register dependency comparator: a non-r0 destination matching either source.
module hz_match #(
  parameter int unsigned REG_W = 3
) (
  input  logic [REG_W-1:0] dest,
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  output logic             hit
);

  assign hit = (dest != '0) && ((dest == src_a) || (dest == src_b));

endmodule

// File: rtl/id_ex_hazard_stage.sv
// Dual-lane ID/EX pipeline register with load-use / intra-bundle RAW hazard
// control, bundle splitting and taken-branch flush.
// Optional: define HAZARD_PERF_CNT_EN to build the saturating stall counter.
module id_ex_hazard_stage #(
  parameter int unsigned REG_W = pipe_pkg::REG_W,
  parameter int unsigned CNT_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  id_ex_hazard_stage_if.slave bus
);
  import pipe_pkg::*;

  hz_state_t state_q, n_state;
  lane_t     ex_q [2];
  lane_t     n_ex [2];
  lane_t     id_l [2];
  logic [3:0] lu_hit;
  logic [1:0] lu_lane;
  logic       intra_hit, intra_raw;
  logic       load_use_run, load_use_split;
  logic       pcw, ifw, fl;

  // Pack the decode fields into lane records.
  always_comb begin
    id_l[0] = '{valid: bus.id_valid, rm: bus.id_rm_1, rn: bus.id_rn_1, rd: bus.id_rd_1,
                regwrite: bus.id_regwrite_1, memread: bus.id_memread_1,
                alusrcb: bus.id_alusrcb_1};
    id_l[1] = '{valid: bus.id_valid, rm: bus.id_rm_2, rn: bus.id_rn_2, rd: bus.id_rd_2,
                regwrite: bus.id_regwrite_2, memread: bus.id_memread_2,
                alusrcb: bus.id_alusrcb_2};
  end

  // One comparator per (EX lane j, decode lane k) pair; index j*2+k.
  for (genvar j = 0; j < 2; j++) begin : g_ex
    for (genvar k = 0; k < 2; k++) begin : g_id
      hz_match #(.REG_W(REG_W)) u_lu (
        .dest  (ex_q[j].rd),
        .src_a (id_l[k].rm),
        .src_b (id_l[k].rn),
        .hit   (lu_hit[j*2+k])
      );
    end
  end

  hz_match #(.REG_W(REG_W)) u_intra (
    .dest  (id_l[0].rd),
    .src_a (id_l[1].rm),
    .src_b (id_l[1].rn),
    .hit   (intra_hit)
  );

  // Collapse comparator hits into per-decode-lane load-use and bundle RAW terms.
  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      lu_lane[k] = (ex_q[0].valid && ex_q[0].memread && lu_hit[k]) ||
                   (ex_q[1].valid && ex_q[1].memread && lu_hit[2+k]);
    end
    load_use_run   = bus.id_valid && (lu_lane[0] || lu_lane[1]);
    load_use_split = bus.id_valid && lu_lane[1];
    intra_raw      = bus.id_valid && bus.id_regwrite_1 && intra_hit;
  end

  // Next-state and next ID/EX contents in priority order: hold, branch, hazards, issue.
  always_comb begin
    n_ex[0] = ex_q[0];
    n_ex[1] = ex_q[1];
    n_state = state_q;
    pcw     = 1'b0;
    ifw     = 1'b0;
    fl      = 1'b0;
    if (!bus.ex_hold) begin
      if (bus.ex_branch_taken) begin
        n_ex[0] = BUBBLE;
        n_ex[1] = BUBBLE;
        fl      = 1'b1;
        pcw     = 1'b1;
        ifw     = 1'b1;
        n_state = RUN;
      end else if (state_q == RUN) begin
        if (load_use_run) begin
          n_ex[0] = BUBBLE;
          n_ex[1] = BUBBLE;
        end else if (intra_raw) begin
          n_ex[0] = issue_lane(id_l[0]);
          n_ex[1] = BUBBLE;
          n_state = SPLIT;
        end else begin
          n_ex[0] = issue_lane(id_l[0]);
          n_ex[1] = issue_lane(id_l[1]);
          pcw     = 1'b1;
          ifw     = 1'b1;
        end
      end else begin
        // Lane 1 of IF/ID already issued; only lane 2 remains.
        if (load_use_split) begin
          n_ex[0] = BUBBLE;
          n_ex[1] = BUBBLE;
        end else begin
          n_ex[0] = BUBBLE;
          n_ex[1] = issue_lane(id_l[1]);
          pcw     = 1'b1;
          ifw     = 1'b1;
          n_state = RUN;
        end
      end
    end
  end

  // State and ID/EX register update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      ex_q[0] <= BUBBLE;
      ex_q[1] <= BUBBLE;
    end else begin
      state_q <= n_state;
      ex_q[0] <= n_ex[0];
      ex_q[1] <= n_ex[1];
    end
  end

  assign bus.pc_write         = pcw && !reset;
  assign bus.if_id_write      = ifw && !reset;
  assign bus.if_id_flush      = fl && !reset;
  assign bus.ID_EX_valid_1    = ex_q[0].valid;
  assign bus.ID_EX_rm_1       = ex_q[0].rm;
  assign bus.ID_EX_rn_1       = ex_q[0].rn;
  assign bus.ID_EX_rd_1       = ex_q[0].rd;
  assign bus.ID_EX_RegWrite_1 = ex_q[0].regwrite;
  assign bus.ID_EX_MemRead_1  = ex_q[0].memread;
  assign bus.ID_EX_ALUSrcB_1  = ex_q[0].alusrcb;
  assign bus.ID_EX_valid_2    = ex_q[1].valid;
  assign bus.ID_EX_rm_2       = ex_q[1].rm;
  assign bus.ID_EX_rn_2       = ex_q[1].rn;
  assign bus.ID_EX_rd_2       = ex_q[1].rd;
  assign bus.ID_EX_RegWrite_2 = ex_q[1].regwrite;
  assign bus.ID_EX_MemRead_2  = ex_q[1].memread;
  assign bus.ID_EX_ALUSrcB_2  = ex_q[1].alusrcb;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count every non-reset cycle in which the PC is stalled, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!pcw && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
